// File: rtl/evt_counter_pkg.sv
// rtl/evt_counter_pkg.sv - shared mode enum and default width for the event counter bank
package evt_counter_pkg;

   localparam int EVT_WIDTH_DEFAULT = 32;
   localparam int EVT_CHANNELS_MAX  = 16;

   typedef enum logic {
      EVT_MODE_WRAP = 1'b0,
      EVT_MODE_SAT  = 1'b1
   } evt_mode_e;

endpackage

// File: rtl/evt_counter_chan.sv
// rtl/evt_counter_chan.sv - one event counter channel with wrap/saturate terminal behaviour
module evt_counter_chan
   import evt_counter_pkg::*;
#(
   parameter int WIDTH = EVT_WIDTH_DEFAULT
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             evt_in,
   input  logic             clr_in,
   input  logic             en_in,
   input  logic             mode_in,
   input  logic [WIDTH-1:0] max_count_in,
   output logic [WIDTH-1:0] count_out,
   output logic             wrap_out,
   output logic             sat_out
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_count;
   logic             r_wrap;

   logic [WIDTH-1:0] w_term;
   logic             w_at_term;
   logic             w_over;
   logic             w_evt;
   evt_mode_e        w_mode;
   logic [WIDTH-1:0] w_count_nxt;
   logic             w_wrap_nxt;

   // M = 0 underflows to all-ones, which gives the full 2^WIDTH count range
   assign w_term    = max_count_in - ONE;
   assign w_at_term = (r_count == w_term);
   assign w_over    = (r_count > w_term);
   assign w_evt     = evt_in & en_in;
   assign w_mode    = evt_mode_e'(mode_in);

   // Next count in priority order: clear, out-of-range recovery, event, hold
   always_comb begin
      w_count_nxt = r_count;
      w_wrap_nxt  = 1'b0;
      if (clr_in) begin
         w_count_nxt = '0;
      end else if (w_over) begin
         // M was lowered under the current count: restart silently
         w_count_nxt = '0;
      end else if (w_evt) begin
         if (!w_at_term) begin
            // r_count < T here, so the increment cannot overflow WIDTH bits
            w_count_nxt = r_count + ONE;
         end else if (w_mode == EVT_MODE_WRAP) begin
            w_count_nxt = '0;
            w_wrap_nxt  = 1'b1;
         end
      end
   end

   // Count and wrap pulse registers, cleared immediately by reset
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_count <= '0;
         r_wrap  <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_wrap  <= w_wrap_nxt;
      end
   end

   assign count_out = r_count;
   assign wrap_out  = r_wrap;
   // Saturation level follows the live mode and modulus, not a registered copy
   assign sat_out   = (w_mode == EVT_MODE_SAT) && w_at_term;

endmodule

// File: rtl/evt_counter_bank.sv
// rtl/evt_counter_bank.sv - bank of independent event counter channels
module evt_counter_bank
   import evt_counter_pkg::*;
#(
   parameter int WIDTH    = EVT_WIDTH_DEFAULT,
   parameter int CHANNELS = 4
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic [CHANNELS-1:0]       evt_in,
   input  logic [CHANNELS-1:0]       clr_in,
   input  logic [CHANNELS-1:0]       en_in,
   input  logic [CHANNELS-1:0]       mode_in,
   input  logic [CHANNELS*WIDTH-1:0] max_count_in,
   output logic [CHANNELS*WIDTH-1:0] count_out,
   output logic [CHANNELS-1:0]       wrap_out,
   output logic [CHANNELS-1:0]       sat_out
);

   // Each channel owns its own slice of every bus; nothing is shared between them
   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      evt_counter_chan #(
         .WIDTH(WIDTH)
      ) u_chan (
         .clk_in       (clk_in),
         .rst_in       (rst_in),
         .evt_in       (evt_in[g]),
         .clr_in       (clr_in[g]),
         .en_in        (en_in[g]),
         .mode_in      (mode_in[g]),
         .max_count_in (max_count_in[g*WIDTH +: WIDTH]),
         .count_out    (count_out[g*WIDTH +: WIDTH]),
         .wrap_out     (wrap_out[g]),
         .sat_out      (sat_out[g])
      );
   end

endmodule
